// File: rtl/nine_seg_pkg.sv
// rtl/nine_seg_pkg.sv - shared types and helpers for the nine-segment row scanner
package nine_seg_pkg;

    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 3;

    typedef logic [8:0] seg_image_t;
    typedef logic [1:0] row_idx_t;

    // Three segment bits belonging to row r; bit c of the result is column c.
    function automatic logic [NUM_COLS-1:0] seg_row(input seg_image_t img, input row_idx_t r);
        logic [NUM_COLS-1:0] slice;
        case (r)
            2'd0:    slice = img[2:0];
            2'd1:    slice = img[5:3];
            default: slice = img[8:6];
        endcase
        return slice;
    endfunction

endpackage

// File: rtl/nine_seg_scan_timer.sv
// rtl/nine_seg_scan_timer.sv - dwell counter and row pointer for the row scan
module nine_seg_scan_timer
    import nine_seg_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] row_idx,
    output logic       load
);

    // A one-cycle dwell still needs a one-bit counter that simply stays at zero.
    localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST     = CW'(DWELL - 1);
    localparam row_idx_t      LAST_ROW = row_idx_t'(NUM_ROWS - 1);

    logic [CW-1:0] dwell_cnt;
    row_idx_t      ptr;

    assign load    = (dwell_cnt == '0);
    assign row_idx = ptr;

    // Count out each slot, and step to the next row whenever a slot starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt <= '0;
            ptr       <= '0;
        end else begin
            dwell_cnt <= (dwell_cnt == LAST) ? '0 : dwell_cnt + 1'b1;
            if (load) begin
                ptr <= (ptr == LAST_ROW) ? '0 : ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nine_segment_row_scanner.sv
// rtl/nine_segment_row_scanner.sv - time-multiplexed 3x3 LED matrix driver
module nine_segment_row_scanner
    import nine_seg_pkg::*;
#(
    parameter int DWELL    = 1,
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8:0]          segments,
    output logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols
);

    logic [1:0]          row_idx;
    logic                load;
    logic [NUM_COLS-1:0] slice;
    logic [NUM_ROWS-1:0] next_rows;

    nine_seg_scan_timer #(
        .DWELL(DWELL)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .row_idx (row_idx),
        .load    (load)
    );

    // Pick out the current row's segments; a blank row keeps its anode off.
    always_comb begin
        slice     = seg_row(segments, row_idx);
        next_rows = '0;
        if (slice != '0) begin
            next_rows = NUM_ROWS'(1) << row_idx;
        end
    end

    // Pins only change at slot start, so the image cannot tear within a slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows <= '0;
            cols <= '1;
        end else if (load) begin
            rows <= next_rows;
            cols <= ~slice;
        end
    end

endmodule

// File: tb/tb_nine_segment_row_scanner.sv
// tb/tb_nine_segment_row_scanner.sv - self-checking bench for nine_segment_row_scanner
module tb_nine_segment_row_scanner;

    logic       clk;
    logic       reset;
    logic [8:0] segments;
    logic [2:0] rows1, cols1, rows4, cols4;

    int n_checks;
    int n_fail;

    nine_segment_row_scanner #(.DWELL(1), .NUM_ROWS(3), .NUM_COLS(3)) dut1 (
        .clk(clk), .reset(reset), .segments(segments), .rows(rows1), .cols(cols1)
    );

    nine_segment_row_scanner #(.DWELL(4), .NUM_ROWS(3), .NUM_COLS(3)) dut4 (
        .clk(clk), .reset(reset), .segments(segments), .rows(rows4), .cols(cols4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edge n after reset release starts a slot when n is a
    // multiple of the dwell, and that slot shows row (n / dwell) mod 3.
    function automatic logic [5:0] slot_out(input int p, input logic [8:0] img);
        logic [2:0] s;
        logic [2:0] r;
        s = 3'((img >> (3 * p)) & 9'd7);
        r = (s != 3'd0) ? 3'(1 << p) : 3'd0;
        return {r, ~s};
    endfunction

    int         n1, n4;
    logic [2:0] m1r, m1c, m4r, m4c;
    logic       started;

    initial started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            n1 = 0; n4 = 0;
            m1r = 3'b000; m1c = 3'b111;
            m4r = 3'b000; m4c = 3'b111;
            started = 1'b1;
        end else begin
            if (n1 % 1 == 0) {m1r, m1c} = slot_out((n1 / 1) % 3, segments);
            if (n4 % 4 == 0) {m4r, m4c} = slot_out((n4 / 4) % 3, segments);
            n1++;
            n4++;
        end
    end

    task automatic check(input string name, input logic [2:0] ar, input logic [2:0] ac,
                         input logic [2:0] er, input logic [2:0] ec);
        n_checks++;
        if (ar !== er || ac !== ec) begin
            n_fail++;
            $display("FAIL %s: got rows=%b cols=%b, expected rows=%b cols=%b", name, ar, ac, er, ec);
        end
    endtask

    task automatic check_bit(input string name, input logic ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: rows1=%b cols1=%b rows4=%b cols4=%b", name, rows1, cols1, rows4, cols4);
        end
    endtask

    // Every cycle: outputs against the model, plus the pin-safety invariants.
    always @(negedge clk) begin
        if (started) begin
            check("model_d1", rows1, cols1, m1r, m1c);
            check("model_d4", rows4, cols4, m4r, m4c);
            check_bit("one_hot_rows", ($countones(rows1) <= 1) && ($countones(rows4) <= 1));
            check_bit("dark_cols", (rows1 != 3'b000 || cols1 == 3'b111) &&
                                   (rows4 != 3'b000 || cols4 == 3'b111));
        end
    end

    // One reset edge, then release with the new image; the next edge is slot 0.
    task automatic do_reset(input logic [8:0] img);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        segments = img;
    endtask

    task automatic run_d1(input string name, input logic [8:0] img,
                          input logic [2:0] er[3], input logic [2:0] ec[3]);
        do_reset(img);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check(name, rows1, cols1, er[k % 3], ec[k % 3]);
        end
    endtask

    logic [2:0] er[3];
    logic [2:0] ec[3];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        segments = 9'h000;

        @(negedge clk);
        @(negedge clk);
        check("reset_d1", rows1, cols1, 3'b000, 3'b111);
        check("reset_d4", rows4, cols4, 3'b000, 3'b111);

        do_reset(9'h000);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("blank_d1", rows1, cols1, 3'b000, 3'b111);
            check("blank_d4", rows4, cols4, 3'b000, 3'b111);
        end

        er = '{3'b000, 3'b010, 3'b000}; ec = '{3'b111, 3'b101, 3'b111};
        run_d1("centre", 9'b000010000, er, ec);

        er = '{3'b001, 3'b010, 3'b100}; ec = '{3'b000, 3'b000, 3'b000};
        run_d1("all_lit", 9'h1FF, er, ec);

        er = '{3'b001, 3'b000, 3'b100}; ec = '{3'b110, 3'b111, 3'b011};
        run_d1("corners", 9'b100000001, er, ec);

        do_reset(9'b000000111);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k < 4 || k == 12) check("d4_row0", rows4, cols4, 3'b001, 3'b000);
            else                  check("d4_dark", rows4, cols4, 3'b000, 3'b111);
        end
        segments = 9'h000;
        for (int k = 13; k < 17; k++) begin
            @(negedge clk);
            if (k < 16) check("d4_no_tear", rows4, cols4, 3'b001, 3'b000);
            else        check("d4_next_slot", rows4, cols4, 3'b000, 3'b111);
        end

        do_reset(9'h1FF);
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_row1", rows1, cols1, 3'b010, 3'b000);
        reset = 1'b1;
        @(negedge clk);
        check("abort_d1", rows1, cols1, 3'b000, 3'b111);
        check("abort_d4", rows4, cols4, 3'b000, 3'b111);
        reset = 1'b0;
        @(negedge clk);
        check("restart_d1", rows1, cols1, 3'b001, 3'b000);
        check("restart_d4", rows4, cols4, 3'b001, 3'b000);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
